// File: rtl/uart_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sched_pkg
//  Description : Shared types and helpers for the UART transmit scheduler.
//                Holds the scheduler state encoding and the default frame
//                length derived from the serializer bit period.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_sched_pkg;

    // Scheduler states: arbitrate, accept one byte, pace one frame
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } sched_state_t;

    // One 8N1 frame is 10 bit periods; two guard cycles keep the next start
    // bit clear of the previous stop bit.
    function automatic int default_frame_clks(input int clks_per_bit);
        return 10 * clks_per_bit + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Scans the request vector
//                starting at the pointer index, wrapping, and returns the
//                first asserted request as a one-hot grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_found
);

    int               w_idx;
    logic [PTR_W-1:0] w_sel;

    // Walk NUM_REQ positions from the pointer; first hit wins
    always_comb begin
        o_gnt   = '0;
        o_found = 1'b0;
        w_idx   = 0;
        w_sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_sel = PTR_W'(w_idx);
            if (!o_found && i_req[w_sel]) begin
                o_gnt[w_sel] = 1'b1;
                o_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Shares one 8N1 UART serializer between NUM_REQ packet
//                sources. A grant is held for a whole packet; bytes are paced
//                by an internal frame timer because the serializer has no
//                busy output. Stalled grantees are revoked after HOLD_TIMEOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 433,
    parameter int FRAME_CLKS   = default_frame_clks(CLKS_PER_BIT),
    parameter int HOLD_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_data_valid,
    output logic [7:0]           tx_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);

    localparam int c_PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_FRAME_W = $clog2(FRAME_CLKS + 1);
    localparam int c_HOLD_W  = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;

    localparam logic [c_FRAME_W-1:0] c_FRAME_LAST = c_FRAME_W'(FRAME_CLKS - 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LIM   =
        c_HOLD_W'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);
    localparam logic [c_PTR_W-1:0]   c_PTR_MAX    = c_PTR_W'(NUM_REQ - 1);

    generate
        if (FRAME_CLKS < 10 * CLKS_PER_BIT + 1) begin : g_bad_frame
            $error("FRAME_CLKS shorter than one serializer frame");
        end
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("NUM_REQ must be within 2..8");
        end
    endgenerate

    sched_state_t          r_state;
    logic [NUM_REQ-1:0]    r_grant;
    logic [c_PTR_W-1:0]    r_owner;
    logic [c_PTR_W-1:0]    r_rr_ptr;
    logic [c_FRAME_W-1:0]  r_frame_cnt;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic                  r_last;
    logic                  r_tx_data_valid;
    logic [7:0]            r_tx_data;

    logic [NUM_REQ-1:0]    w_arb_gnt;
    logic                  w_arb_found;
    logic [c_PTR_W-1:0]    w_arb_idx;
    logic [7:0]            w_sel_data;
    logic                  w_sel_last;
    logic                  w_hs;
    logic [c_PTR_W-1:0]    w_next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_PTR_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_arb_gnt),
        .o_found (w_arb_found)
    );

    // Encode the arbiter pick and mux the current owner's byte and last flag
    always_comb begin
        w_arb_idx  = '0;
        w_sel_data = 8'h00;
        w_sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_gnt[i]) begin
                w_arb_idx = c_PTR_W'(i);
            end
            if (r_grant[i]) begin
                w_sel_data = req_data[8*i +: 8];
                w_sel_last = req_last[i];
            end
        end
    end

    assign req_ready     = (r_state == ST_SEND) ? (req_valid & r_grant) : '0;
    assign w_hs          = |req_ready;
    assign w_next_ptr    = (r_owner == c_PTR_MAX) ? '0 : r_owner + 1'b1;
    assign grant         = r_grant;
    assign tx_data_valid = r_tx_data_valid;
    assign tx_data       = r_tx_data;
    assign busy          = (r_state != ST_IDLE);

    // Scheduler FSM: arbitrate in IDLE, take one byte in SEND, pace in WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_WAIT;
            r_frame_cnt     <= c_FRAME_LAST;
            r_grant         <= '0;
            r_owner         <= '0;
            r_rr_ptr        <= '0;
            r_last          <= 1'b1;
            r_hold_cnt      <= '0;
            r_tx_data_valid <= 1'b0;
            r_tx_data       <= 8'h00;
        end else begin
            r_tx_data_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_hold_cnt <= '0;
                    if (w_arb_found) begin
                        r_grant <= w_arb_gnt;
                        r_owner <= w_arb_idx;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_hs) begin
                        r_tx_data_valid <= 1'b1;
                        r_tx_data       <= w_sel_data;
                        r_last          <= w_sel_last;
                        r_frame_cnt     <= c_FRAME_LAST;
                        r_hold_cnt      <= '0;
                        r_state         <= ST_WAIT;
                    end else if (HOLD_TIMEOUT != 0 && r_hold_cnt == c_HOLD_LIM) begin
                        // Grantee stalled mid-packet too long: hand the wire on
                        r_grant    <= '0;
                        r_rr_ptr   <= w_next_ptr;
                        r_hold_cnt <= '0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (r_frame_cnt == '0) begin
                        if (r_last) begin
                            // No owner exists after reset, so the pointer stays put
                            if (|r_grant) begin
                                r_rr_ptr <= w_next_ptr;
                            end
                            r_grant <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_SEND;
                        end
                    end else begin
                        r_frame_cnt <= r_frame_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_WAIT;
                    r_frame_cnt <= c_FRAME_LAST;
                    r_grant     <= '0;
                    r_last      <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_sched
//  Description : Directed self-checking bench for uart_tx_sched. Per-source
//                byte queues feed the requesters; expected serializer bytes
//                and owners are queued as stimulus is issued and compared at
//                every tx_data_valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int N   = 4;
    localparam int CPB = 4;
    localparam int FR  = 42;
    localparam int HT  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_data_valid;
    logic [7:0]     tx_data;
    logic [N-1:0]   grant;
    logic           busy;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NUM_REQ      (N),
        .CLKS_PER_BIT (CPB),
        .FRAME_CLKS   (FR),
        .HOLD_TIMEOUT (HT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data_valid (tx_data_valid),
        .tx_data       (tx_data),
        .grant         (grant),
        .busy          (busy)
    );

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [7:0]   data;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] src_q[N][$];
    int         pulse_cyc[$];
    int         checks    = 0;
    int         errors    = 0;
    int         cyc       = 0;
    int         pulse_cnt = 0;
    logic       s_busy    = 1'b0;
    logic       prev_v    = 1'b0;
    logic [N-1:0] s_ready = '0;
    logic [N-1:0] s_grant = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    task automatic drive_sources();
        logic [8:0] h;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                h = src_q[i][0];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = h[7:0];
                req_last[i]        = h[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    // One clock: sample/score on negedge, then retire accepted bytes after posedge
    task automatic tick();
        exp_t w;
        @(negedge clk);
        cyc++;
        s_busy  = busy;
        s_ready = req_ready;
        s_grant = grant;
        if (tx_data_valid === 1'b1) begin
            chk("pulse_width", {31'd0, prev_v}, 32'd0);
            pulse_cnt++;
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {24'd0, tx_data}, 32'h100);
            end else begin
                w = exp_q.pop_front();
                chk("tx_data", {24'd0, tx_data}, {24'd0, w.data});
                chk("grant_at_pulse", {28'd0, grant}, {28'd0, w.gnt});
            end
        end
        prev_v = tx_data_valid;
        @(posedge clk);
        #1;
        if (rst === 1'b0) begin
            for (int i = 0; i < N; i++) begin
                if (s_ready[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                end
            end
        end
        drive_sources();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (s_busy && n < budget);
        if (s_busy) chk({tag, "_idle_timeout"}, {31'd0, s_busy}, 32'd0);
    endtask

    task automatic run_until_drained(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) chk({tag, "_drain_timeout"}, exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        drive_sources();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int p0;
        int pc;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;

        // Reset state and post-reset frame wait with no requests
        do_reset();
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_rr_ptr", {30'd0, dut.r_rr_ptr}, 32'd0);
        n = 0;
        tick();
        while (s_busy && n < 200) begin
            n++;
            tick();
        end
        chk("reset_wait_len", n, FR);
        chk("idle_grant", {28'd0, grant}, 32'd0);
        chk("no_pulse_after_reset", pulse_cnt, 32'd0);

        // Requester 1: three-byte packet
        src_q[1].push_back({1'b0, 8'h41});
        src_q[1].push_back({1'b0, 8'h42});
        src_q[1].push_back({1'b1, 8'h43});
        exp_q.push_back({4'b0010, 8'h41});
        exp_q.push_back({4'b0010, 8'h42});
        exp_q.push_back({4'b0010, 8'h43});
        drive_sources();
        p0 = pulse_cyc.size();
        run_until_drained("t2", 400);
        if (pulse_cyc.size() >= p0 + 3) begin
            chk("t2_gap1", pulse_cyc[p0+1] - pulse_cyc[p0], FR + 1);
            chk("t2_gap2", pulse_cyc[p0+2] - pulse_cyc[p0+1], FR + 1);
        end
        run_until_idle("t2", 100);
        chk("t2_grant_released", {28'd0, grant}, 32'd0);
        chk("t2_rr_ptr", {30'd0, dut.r_rr_ptr}, 32'd2);

        // Requesters 0 and 2 contend from rr_ptr=0: whole packets, no interleave
        do_reset();
        run_until_idle("t3_rst", 100);
        src_q[0].push_back({1'b0, 8'hA0});
        src_q[0].push_back({1'b1, 8'hA1});
        src_q[2].push_back({1'b0, 8'hC0});
        src_q[2].push_back({1'b1, 8'hC1});
        exp_q.push_back({4'b0001, 8'hA0});
        exp_q.push_back({4'b0001, 8'hA1});
        exp_q.push_back({4'b0100, 8'hC0});
        exp_q.push_back({4'b0100, 8'hC1});
        drive_sources();
        run_until_drained("t3", 600);
        run_until_idle("t3", 100);
        chk("t3_rr_ptr", {30'd0, dut.r_rr_ptr}, 32'd3);
        chk("t3_grant_released", {28'd0, grant}, 32'd0);

        // All four stream 1-byte packets: strict rotation
        do_reset();
        run_until_idle("t4_rst", 100);
        for (int i = 0; i < N; i++) begin
            src_q[i].push_back({1'b1, 8'h10 + 8'(i)});
            src_q[i].push_back({1'b1, 8'h20 + 8'(i)});
        end
        for (int i = 0; i < N; i++) exp_q.push_back({4'(1 << i), 8'h10 + 8'(i)});
        for (int i = 0; i < N; i++) exp_q.push_back({4'(1 << i), 8'h20 + 8'(i)});
        drive_sources();
        run_until_drained("t4", 1200);
        run_until_idle("t4", 100);
        chk("t4_tx_data_hold", {24'd0, tx_data}, 32'h23);
        chk("t4_rr_ptr", {30'd0, dut.r_rr_ptr}, 32'd0);

        // Requester 3 stalls mid-packet: revoked after WAIT plus HT SEND cycles
        src_q[3].push_back({1'b0, 8'h5A});
        exp_q.push_back({4'b1000, 8'h5A});
        drive_sources();
        p0 = pulse_cyc.size();
        run_until_drained("t5", 200);
        pc = (pulse_cyc.size() > p0) ? pulse_cyc[p0] : cyc;
        n = 0;
        do begin
            tick();
            n++;
            if (cyc == pc + FR + 3) chk("t5_grant_held", {28'd0, s_grant}, 32'h8);
        end while (s_busy && n < 200);
        chk("t5_revoke_time", cyc - pc, FR + HT);
        chk("t5_grant_revoked", {28'd0, s_grant}, 32'd0);
        chk("t5_rr_ptr", {30'd0, dut.r_rr_ptr}, 32'd0);

        // Reset mid-WAIT of a 2-byte packet: second byte abandoned
        src_q[1].push_back({1'b0, 8'hB0});
        src_q[1].push_back({1'b1, 8'hB1});
        exp_q.push_back({4'b0010, 8'hB0});
        drive_sources();
        run_until_drained("t6", 200);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        drive_sources();
        tick();
        chk("t6_rst_grant", {28'd0, grant}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd1);
        chk("t6_rst_txv", {31'd0, tx_data_valid}, 32'd0);
        src_q[1].push_back({1'b1, 8'hD0});
        exp_q.push_back({4'b0010, 8'hD0});
        rst = 1'b0;
        drive_sources();
        n = 0;
        do begin
            tick();
            n++;
        end while (s_grant == '0 && n < 200);
        chk("t6_first_grant_cycle", n, FR + 2);
        run_until_drained("t6b", 200);
        run_until_idle("t6b", 100);
        chk("total_pulses", pulse_cnt, 32'd18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
